// File: rtl/speed_ctrl.sv
// rtl/speed_ctrl.sv - sequencer for the two-sensor speed measurement datapath
module speed_ctrl #(
    parameter int WIDTH_SPEED = 14,
    parameter int SYS_FREQ    = 10000000,
    parameter int SPEED_LIMIT = 60,
    parameter int TIMEOUT_MS  = 2000,
    parameter int HOLD_MS     = 3000,
    parameter int DONE_WDOG   = 40
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sen1,
    input  logic                   sen2,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   en,
    output logic                   dis,
    output logic [WIDTH_SPEED-1:0] speed_out,
    output logic                   speed_valid,
    output logic                   overspeed,
    output logic                   err
);

    localparam int TICKS  = SYS_FREQ / 1000;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int MS_MAX = (TIMEOUT_MS > HOLD_MS) ? TIMEOUT_MS : HOLD_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam int WD_W   = (DONE_WDOG > 1) ? $clog2(DONE_WDOG) : 1;

    typedef enum logic [2:0] {
        IDLE, START, MEASURE, CALC, WAIT, EVAL, HOLD
    } state_t;

    state_t            state;
    logic [1:0]        s1_sync;
    logic [1:0]        s2_sync;
    logic              s1_prev;
    logic              s2_prev;
    logic              s1_rise;
    logic              s2_rise;
    logic [TICK_W-1:0] tick_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [WD_W-1:0]   wdog;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sync <= '0;
            s2_sync <= '0;
            s1_prev <= 1'b0;
            s2_prev <= 1'b0;
        end else begin
            s1_sync <= {s1_sync[0], sen1};
            s2_sync <= {s2_sync[0], sen2};
            s1_prev <= s1_sync[1];
            s2_prev <= s2_sync[1];
        end
    end

    assign s1_rise = s1_sync[1] & ~s1_prev;
    assign s2_rise = s2_sync[1] & ~s2_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            ms_cnt      <= '0;
            wdog        <= '0;
            init        <= 1'b0;
            count       <= 1'b0;
            cal         <= 1'b0;
            up          <= 1'b0;
            down        <= 1'b0;
            en          <= 1'b0;
            dis         <= 1'b0;
            speed_out   <= '0;
            speed_valid <= 1'b0;
            overspeed   <= 1'b0;
            err         <= 1'b0;
        end else begin
            init        <= 1'b0;
            cal         <= 1'b0;
            up          <= 1'b0;
            down        <= 1'b0;
            en          <= 1'b0;
            dis         <= 1'b0;
            speed_valid <= 1'b0;
            err         <= 1'b0;

            // The ms timer only runs while it is being watched; entry into
            // MEASURE/HOLD restarts it via the later assignments below.
            if (state == MEASURE || state == HOLD) begin
                if (tick_cnt == TICK_W'(TICKS - 1)) begin
                    tick_cnt <= '0;
                    ms_cnt   <= ms_cnt + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (s1_rise) begin
                        init  <= 1'b1;
                        up    <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    count    <= 1'b1;
                    tick_cnt <= '0;
                    ms_cnt   <= '0;
                    state    <= MEASURE;
                end
                MEASURE: begin
                    if (ms_cnt >= MS_W'(TIMEOUT_MS)) begin
                        count <= 1'b0;
                        err   <= 1'b1;
                        init  <= 1'b1;
                        state <= IDLE;
                    end else if (s2_rise) begin
                        count <= 1'b0;
                        // A zero-ms gap would make the datapath divide by zero.
                        if (ms_cnt != '0) begin
                            down  <= 1'b1;
                            state <= CALC;
                        end else begin
                            err   <= 1'b1;
                            init  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                CALC: begin
                    cal   <= 1'b1;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        speed_out   <= speed;
                        speed_valid <= 1'b1;
                        state       <= EVAL;
                    end else if (wdog == WD_W'(DONE_WDOG - 1)) begin
                        err   <= 1'b1;
                        init  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                EVAL: begin
                    if (speed_out > WIDTH_SPEED'(SPEED_LIMIT)) begin
                        en        <= 1'b1;
                        overspeed <= 1'b1;
                        tick_cnt  <= '0;
                        ms_cnt    <= '0;
                        state     <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (ms_cnt >= MS_W'(HOLD_MS)) begin
                        dis       <= 1'b1;
                        overspeed <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
